// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a 2-bit saturating
// direction counter per entry. Lookup is combinational (IF stage); training and
// mispredict detection come from the EX stage.
// Optional build macro: BP_PERF_CNT_EN adds perf_branches / perf_mispredicts.
module branch_predictor #(
   parameter int unsigned IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        mispredict
`ifdef BP_PERF_CNT_EN
   ,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
`endif
);

   localparam int unsigned TAG_W = 32 - IDX_W - 2;
   localparam int unsigned DEPTH = 1 << IDX_W;

   logic [DEPTH-1:0] valid_q;
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [1:0]       ctr_q    [DEPTH];

   logic [IDX_W-1:0] if_idx, upd_idx;
   logic [TAG_W-1:0] if_tag, upd_tag;
   logic             if_hit, upd_hit;

   assign if_idx  = if_pc[IDX_W+1:2];
   assign if_tag  = if_pc[31:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[31:IDX_W+2];

   // Combinational lookup for the fetch PC and for the resolving branch PC.
   always_comb begin
      if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      pred_taken  = !rst && if_hit && ctr_q[if_idx][1];
      pred_target = if_hit ? target_q[if_idx] : '0;
      mispredict  = !rst && upd_valid &&
                    ((upd_pred_taken != upd_taken) ||
                     (upd_taken && (upd_pred_target != upd_target)));
   end

   // Table training; reset only clears valid bits, the payload is don't-care.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
               target_q[upd_idx] <= upd_target;
            end else begin
               if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= 2'b10;
         end
      end
   end

`ifdef BP_PERF_CNT_EN
   // Free-running event counters, wrapping naturally at 32 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (upd_valid)  perf_branches    <= perf_branches + 32'd1;
         if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Sits in the IF stage and supplies the predicted direction and target for each fetch PC.
- Trained from the EX stage by the branch-condition result, i.e. the BResult of beq/bne/bgtz/blez/bgez/bltz, together with the resolved target.
- Also flags mispredicts so the pipeline can flush.

Parameters:
- IDX_W, 6: index width; the table has 2**IDX_W entries.
- TAG_W, 32-IDX_W-2: tag width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  32  fetch PC to predict.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  32  predicted target; valid when pred_taken=1.
- upd_valid  in  1  EX stage holds a resolved conditional branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual direction (BResult).
- upd_target  in  32  actual taken target.
- upd_pred_taken  in  1  prediction that was made for this branch, piped from IF.
- upd_pred_target  in  32  predicted target, piped from IF.
- mispredict  out  1  combinational; the EX-stage prediction was wrong.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Index is pc[IDX_W+1:2]; tag is pc[31:IDX_W+2]. pc[1:0] is ignored.
- Reset (async, rst=1): every valid bit clears to 0. ctr, tag and target are don't-care.
  - pred_taken=0 and mispredict=0 while in reset.
  - Reset asserted mid-update aborts the update; no entry is written.
- Lookup is combinational with zero latency.
  - hit = valid[idx] && tag[idx]==if_pc tag.
  - pred_taken = hit && ctr[1].
  - pred_target = target[idx] on a hit, otherwise 0.
- mispredict = upd_valid && (upd_pred_taken!=upd_taken || (upd_taken && upd_pred_target!=upd_target)). It is 0 when upd_valid=0.
- Update is committed on the rising edge when upd_valid=1. Let uhit be the hit evaluated for upd_pc.
  - uhit, taken: ctr saturating-increments (3 stays 3); target<=upd_target.
  - uhit, not taken: ctr saturating-decrements (0 stays 0); target unchanged.
  - miss, taken: allocate the entry. valid<=1, tag<=upd_pc tag, target<=upd_target, ctr<=2'b10 (weakly taken). Any previous occupant of that index is replaced.
  - miss, not taken: no state change. Not-taken branches are never allocated.
- Simultaneous lookup and update of the same index in one cycle: the lookup returns the pre-update state, with no write-through bypass. The new state is visible from the next cycle.
- upd_valid=0: table is unchanged.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined, two 32-bit output ports are added: perf_branches and perf_mispredicts.
  - perf_branches increments on every cycle with upd_valid=1.
  - perf_mispredicts increments on every cycle with mispredict=1.
  - Both wrap from 0xFFFFFFFF to 0.
  - Both are async-cleared to 0 by rst.
- When undefined, the ports and counters do not exist. Predictor behaviour is identical in both builds.

Test Plan:
- Reset then lookup: if_pc=0x00400010 -> pred_taken=0, pred_target=0.
- Taken miss allocation: one update with upd_pc=0x00400010, upd_taken=1, upd_target=0x00400100, upd_pred_taken=0 -> mispredict=1 in that cycle. Next cycle, lookup of 0x00400010 -> pred_taken=1, pred_target=0x00400100, ctr=10.
- Saturation: three more taken updates -> ctr=11. Then one not-taken update -> ctr=10, pred_taken=1 still. A second not-taken update -> ctr=01, pred_taken=0.
- Alias/tag check: after the allocation above, lookup 0x00400110, which has the same index and a different tag -> pred_taken=0. A taken update at 0x00400110 with target 0x00400200 replaces the entry, so lookup of 0x00400010 -> pred_taken=0.
- Same-cycle read/write and reset: update and lookup 0x00400020 in the same cycle -> the lookup shows a miss, and the next cycle shows a hit. Pulse rst asynchronously between edges -> pred_taken drops to 0 immediately and all entries miss afterwards.
- Perf counters (with BP_PERF_CNT_EN): 5 updates, 2 of which mispredict -> perf_branches=5, perf_mispredicts=2. Preload near wrap: 0xFFFFFFFF plus one update -> perf_branches=0.
